axil_csr_bank: RTL
==================

Name: axil_csr_bank

Overview:
Parametrised AXI4-Lite slave CSR bank that replaces the fixed four-register control interface of the ECDSA wrapper. Register 0 is a COMMAND/STATUS register with a start/busy/done/error handshake to the compute core. Registers 1..NUM_REGS-1 are read/write configuration words, such as the address-table base, ARGC and the result address. It sits between the PS AXI-Lite port (s_axi_csrs) and the core FSM.

Parameters:
NUM_REGS, 8, number of 32-bit registers, including COMMAND at index 0; range 2..64.
ADDR_W, 12, AXI-Lite byte-address width.
DATA_W, 32, register and bus data width; fixed at 32, with WSTRB of DATA_W/8 bits.

Ports:
clk  in  1  single system clock
rst  in  1  synchronous reset, active-high
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
cmd_start  out  1  one-cycle start pulse to the core
core_done  in  1  one-cycle completion pulse from the core
busy  out  1  core running
cfg_regs  out  (NUM_REGS-1)*32  registers 1..N-1, concatenated; register k occupies bits [(k-1)*32 +: 32]

Behaviour:
- Reset: all ready, valid and resp outputs are 0; rdata=0; cmd_start=0; busy=0; done=0; err=0; cfg_regs=0. Reset mid-transaction drops any captured AW/W/AR and any pending B/R. No response is issued for dropped transactions.
- Decode: index = addr[ADDR_W-1:2]; addr[1:0] is ignored. index >= NUM_REGS is out of range.
- Write address channel: awready=1 whenever no AW is captured and bvalid=0. The handshake captures awaddr.
- Write data channel: wready=1 whenever no W is captured and bvalid=0. The handshake captures wdata and wstrb.
- AW and W may arrive in either order or in the same cycle.
- Write commit: occurs in the cycle after both AW and W are captured (one-cycle commit latency). In that same cycle the buffers clear, bvalid=1 and bresp is set. bvalid holds until bready; B completes on the cycle with bvalid and bready both high.
- Configuration register write (index 1..N-1): each byte lane is updated only where its strobe bit is 1. bresp=OKAY.
- Out-of-range write: no register changes; bresp=SLVERR.
- COMMAND write, bit0=1 with busy=0: cmd_start pulses in the commit cycle+1, busy=1, done=0.
- COMMAND write, bit0=1 with busy=1: the start is ignored, err=1, bresp=OKAY.
- COMMAND write, bit0=0: clears done and err.
- COMMAND write strobes: only wstrb[0] is honoured. A COMMAND write with wstrb[0]=0 is a no-op with bresp=OKAY.
- core_done while busy=1: busy is cleared to 0 and done is set to 1 on the next clock edge.
- core_done while busy=0: ignored.
- core_done in the same cycle as a COMMAND clear write: done ends at 1 (done takes priority).
- core_done in the same cycle as a start write: the start is treated as arriving while busy, so it is ignored and err=1.
- Read address channel: arready=1 whenever rvalid=0. The handshake launches the read.
- Read data: rvalid=1 on the next cycle with rdata and rresp registered. rdata is held stable until rready.
- Read of index 0: returns {29'b0, err, busy, done}.
- Read of a configuration register: returns its value with rresp=OKAY.
- Out-of-range read: returns rdata=0 with rresp=SLVERR.
- Channel independence: reads and writes proceed independently, each with at most one outstanding transaction.
- Simultaneous read and commit of the same register: the read returns the pre-commit value.
- busy output mirrors the internal busy bit.

Test Plan:
- Configuration write and read-back: write 0x280 to byte address 4, 3 to address 8 and 0x200 to address 12, each with wstrb=F, then read each back. Required: bresp=OKAY, rdata equals each written value, and cfg_regs bits [95:0] = {0x200, 3, 0x280}.
- Channel ordering and strobes: present W two cycles before AW, then AW and W in the same cycle. Required: both commits occur with one-cycle latency. A write of 0xAABBCCDD with wstrb=0101 to address 4, starting from 0x280, gives 0x00BB02DD. bvalid must hold while bready is held low for 5 cycles.
- Command handshake: write 1 to address 0. Required: a single cmd_start pulse and STATUS reads 0x2. Drive core_done for one cycle; required: STATUS reads 0x1. Write 0 to address 0; required: STATUS reads 0x0.
- Start while busy: write 1 twice to address 0. Required: exactly one cmd_start pulse and STATUS reads 0x6. Pulse core_done, then write 0; required: STATUS reads 0x0.
- Out-of-range access (NUM_REGS=8): write and read address 0x020. Required: SLVERR on both, rdata=0, and no change to any register.
- Reset mid-operation: assert rst while busy=1 and a read is pending (rvalid=1). Required: on the next cycle all outputs are 0, STATUS reads 0x0, and cfg_regs=0.

Source files
------------

// File: rtl/axil_csr_bank.sv
// AXI4-Lite CSR bank: register 0 is COMMAND/STATUS with a start/busy/done/error
// handshake to the compute core; registers 1..NUM_REGS-1 are byte-strobed config words.
module axil_csr_bank #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                s_axi_awaddr,
    input  logic                             s_axi_awvalid,
    output logic                             s_axi_awready,
    input  logic [DATA_W-1:0]                s_axi_wdata,
    input  logic [DATA_W/8-1:0]              s_axi_wstrb,
    input  logic                             s_axi_wvalid,
    output logic                             s_axi_wready,
    output logic [1:0]                       s_axi_bresp,
    output logic                             s_axi_bvalid,
    input  logic                             s_axi_bready,
    input  logic [ADDR_W-1:0]                s_axi_araddr,
    input  logic                             s_axi_arvalid,
    output logic                             s_axi_arready,
    output logic [DATA_W-1:0]                s_axi_rdata,
    output logic [1:0]                       s_axi_rresp,
    output logic                             s_axi_rvalid,
    input  logic                             s_axi_rready,
    output logic                             cmd_start,
    input  logic                             core_done,
    output logic                             busy,
    output logic [(NUM_REGS-1)*DATA_W-1:0]   cfg_regs
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int NB    = DATA_W / 8;
    localparam int CFG_W = (NUM_REGS - 1) * DATA_W;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic              aw_full_q, aw_full_d;
    logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
    logic              w_full_q, w_full_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [NB-1:0]     w_strb_q, w_strb_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [CFG_W-1:0]  cfg_q, cfg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cmd_start_q, cmd_start_d;

    logic              aw_hs, w_hs, ar_hs, commit;
    logic [IDX_W-1:0]  ar_idx;
    logic              unused_addr_bits;

    // Ready is forced low while reset is held so no handshake can land during reset.
    assign s_axi_awready = !rst && !aw_full_q && !bvalid_q;
    assign s_axi_wready  = !rst && !w_full_q && !bvalid_q;
    assign s_axi_arready = !rst && !rvalid_q;

    assign aw_hs  = s_axi_awvalid && s_axi_awready;
    assign w_hs   = s_axi_wvalid && s_axi_wready;
    assign ar_hs  = s_axi_arvalid && s_axi_arready;
    assign commit = aw_full_q && w_full_q;
    assign ar_idx = s_axi_araddr[ADDR_W-1:2];
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_comb begin
        aw_full_d   = aw_full_q;
        aw_idx_d    = aw_idx_q;
        w_full_d    = w_full_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        cfg_d       = cfg_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        cmd_start_d = 1'b0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi_awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi_wdata;
            w_strb_d = s_axi_wstrb;
        end
        if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (aw_idx_q < IDX_W'(NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
            if (aw_idx_q == '0 && w_strb_q[0]) begin
                if (w_data_q[0]) begin
                    if (busy_q) begin
                        err_d = 1'b1;
                    end else begin
                        cmd_start_d = 1'b1;
                        busy_d      = 1'b1;
                        done_d      = 1'b0;
                    end
                end else begin
                    done_d = 1'b0;
                    err_d  = 1'b0;
                end
            end
            for (int k = 1; k < NUM_REGS; k++) begin
                if (aw_idx_q == IDX_W'(k)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_strb_q[b]) begin
                            cfg_d[(k-1)*DATA_W + b*8 +: 8] = w_data_q[b*8 +: 8];
                        end
                    end
                end
            end
        end

        // Completion is applied after any command write so done wins over a clear.
        if (core_done && busy_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
        end

        if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            if (ar_idx == '0) begin
                rdata_d = {{(DATA_W-3){1'b0}}, err_q, busy_q, done_q};
                rresp_d = RESP_OKAY;
            end
            for (int k = 1; k < NUM_REGS; k++) begin
                if (ar_idx == IDX_W'(k)) begin
                    rdata_d = cfg_q[(k-1)*DATA_W +: DATA_W];
                    rresp_d = RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q   <= 1'b0;
            aw_idx_q    <= '0;
            w_full_q    <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= '0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            cfg_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_start_q <= 1'b0;
        end else begin
            aw_full_q   <= aw_full_d;
            aw_idx_q    <= aw_idx_d;
            w_full_q    <= w_full_d;
            w_data_q    <= w_data_d;
            w_strb_q    <= w_strb_d;
            bvalid_q    <= bvalid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            cfg_q       <= cfg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_start_q <= cmd_start_d;
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign cmd_start    = cmd_start_q;
    assign busy         = busy_q;
    assign cfg_regs     = cfg_q;

endmodule
